mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester, single-port memory arbiter for the NPC core. Shares one memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write). Exactly one transaction is outstanding at a time. Round-robin on ties, registered responses, and a wait-cycle timeout that aborts a hung transaction.

## Interface
Parameters:
- AW, 64, address width
- DW, 64, data width; byte mask width is DW/8
- TIMEOUT, 255, max cycles in WAIT before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- if_req  in  1  IF read request; held with if_addr until if_gnt
- if_addr  in  AW  IF address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  DW  fetched data
- if_err  out  1  transaction timed out; qualified by if_rvalid
- lsu_req  in  1  LSU request; held with all lsu_* fields until lsu_gnt
- lsu_we  in  1  1 = write, 0 = read
- lsu_addr  in  AW  LSU address
- lsu_wdata  in  DW  write data
- lsu_wmask  in  DW/8  byte write mask
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  one-cycle pulse: read data or write completion
- lsu_rdata  out  DW  read data; 0 for writes
- lsu_err  out  1  timed out; qualified by lsu_rvalid
- mem_valid  out  1  request to memory; held until mem_ready
- mem_ready  in  1  memory accepts request
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  latched request fields
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, arbitration:
  - Only LSU requesting -> grant LSU. Only IF requesting -> grant IF.
  - Both requesting -> grant the requester not granted last. last_grant resets to IF, so the first tie goes to LSU.
  - On grant, the gnt output is asserted combinationally in the same cycle.
  - The owner's fields are latched at that edge. FSM goes to REQ and last_grant updates.
- IF transactions drive mem_we=0, mem_wmask=0, mem_wdata=0.
- REQ:
  - mem_valid=1 with the latched fields.
  - mem_ready=1 and mem_rvalid=1 in the same cycle -> capture data and complete; go to IDLE.
  - mem_ready=1 alone -> WAIT. mem_ready=0 -> stay in REQ.
- WAIT:
  - mem_valid=0. The wait counter increments each cycle.
  - mem_rvalid=1 -> capture mem_rdata (writes capture 0) and complete; go to IDLE.
  - Counter reaches TIMEOUT with no mem_rvalid -> complete with err=1 and rdata=0; go to IDLE.
- Completion: the owner's rvalid/rdata/err are registered and appear the cycle after the completing edge condition. Exactly one rvalid pulse is produced per grant.
- mem_rvalid is ignored in IDLE, and in REQ unless mem_ready=1. Late responses after a timeout are dropped.
- The non-owner's rvalid is never asserted. Requests arriving outside IDLE wait; gnt stays 0.
- Wait counter: 8 bits, or ceil(log2(TIMEOUT+1)) bits. Cleared on entry to WAIT. It does not run in REQ, so the timeout covers response wait only.

## Timing
- Reset values:
  - State IDLE, last_grant=IF, counter=0.
  - All gnt/rvalid/err/mem_valid outputs = 0.
  - rdata outputs = 0; mem_* field registers = 0.
- Reset mid-transaction: aborts immediately to IDLE. No rvalid is issued for the lost transaction, and any subsequent mem_rvalid is ignored.
- Minimum latency, zero-wait memory (ready+rvalid in one cycle):
  - gnt at cycle 0, mem_valid at cycle 1, owner rvalid at cycle 2.
- Back-to-back: the cycle in which rvalid pulses, the FSM is in IDLE and may grant again. Peak throughput is one transaction per 2 cycles.
- Memory with ready at cycle 1 and rvalid at cycle 1+N: owner rvalid at cycle 2+N.
- Timeout: with TIMEOUT=T, entering WAIT at cycle k and no response, err rvalid appears at cycle k+T+1.
- gnt is combinational from req and state; all other outputs are registered.

## Test plan
- IF only, zero-wait memory, if_addr=0x80000000, mem_rdata=0x00100073 -> if_gnt cycle 0, mem_valid cycle 1 with mem_we=0 and mem_wmask=0, if_rvalid cycle 2 with if_rdata=0x00100073.
- Simultaneous if_req and lsu_req held for 4 transactions after reset -> grant order LSU, IF, LSU, IF; each gnt is a single pulse.
- LSU write: addr 0x80001000, wdata 0xDEADBEEF_CAFEF00D, wmask 0x0F, memory ready after 3 cycles and rvalid 2 cycles later -> mem fields stable while mem_valid=1; lsu_rvalid with lsu_rdata=0 and lsu_err=0.
- TIMEOUT=4, memory accepts but never responds -> lsu_rvalid=1 and lsu_err=1 exactly 5 cycles after entering WAIT. A late mem_rvalid is ignored, and the next IF grant proceeds normally.
- rst pulsed while in WAIT, followed by mem_rvalid -> all outputs 0, no rvalid, FSM in IDLE; the next tie grants LSU.
- Request dropped at the mem side: mem_ready=0 for 10 cycles -> mem_valid held with stable fields, no counter advance, no timeout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF, read-only)
// and the load/store unit (LSU, read/write). Only one transaction is outstanding
// at a time. Ties alternate between the requesters, responses are registered, and
// a wait-cycle timeout aborts a transaction whose response never arrives.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   if_req/if_addr            IF read request (held until if_gnt)
//   if_gnt                    IF accepted this cycle (combinational)
//   if_rvalid/if_rdata/if_err IF completion pulse, data, timeout flag
//   lsu_req/we/addr/wdata/wmask  LSU request (held until lsu_gnt)
//   lsu_gnt                   LSU accepted this cycle (combinational)
//   lsu_rvalid/rdata/err      LSU completion pulse, data (0 on writes), timeout flag
//   mem_valid + mem_* fields  request to memory, held until mem_ready
//   mem_ready                 memory accepts the request
//   mem_rvalid/mem_rdata      memory response
module mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;          // 1 = LSU owns the port
  logic            last_grant_q, last_grant_d; // 1 = LSU granted last
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wmask_q, mem_wmask_d;
  logic            if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;

  logic            grant_if, grant_lsu;
  logic            done, done_err;
  logic [DW-1:0]   done_data;

  // Arbitration only happens in IDLE; a tie goes to whoever was not served last.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE) begin
      if (if_req && lsu_req) begin
        grant_lsu = !last_grant_q;
        grant_if  = last_grant_q;
      end else begin
        grant_lsu = lsu_req;
        grant_if  = if_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    done         = 1'b0;
    done_err     = 1'b0;
    done_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          state_d      = REQ;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          mem_we_d     = lsu_we;
          mem_addr_d   = lsu_addr;
          mem_wdata_d  = lsu_wdata;
          mem_wmask_d  = lsu_wmask;
        end else if (grant_if) begin
          state_d      = REQ;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_wmask_d  = '0;
        end
      end
      REQ: begin
        // A response is only meaningful once the request has been accepted.
        if (mem_ready && mem_rvalid) begin
          state_d   = IDLE;
          done      = 1'b1;
          done_data = mem_we_q ? '0 : mem_rdata;
        end else if (mem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d   = IDLE;
          done      = 1'b1;
          done_data = mem_we_q ? '0 : mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_CNT)) begin
          state_d  = IDLE;
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_d  = (state_d == REQ);
    if_rvalid_d  = done && !owner_q;
    if_err_d     = done && !owner_q && done_err;
    if_rdata_d   = (done && !owner_q) ? done_data : if_rdata_q;
    lsu_rvalid_d = done && owner_q;
    lsu_err_d    = done && owner_q && done_err;
    lsu_rdata_d  = (done && owner_q) ? done_data : lsu_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign if_gnt     = grant_if;
  assign lsu_gnt    = grant_lsu;
  assign if_rvalid  = if_rvalid_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a scripted memory model, a scoreboard of expected
// completions (owner, data, err, cycle) pushed at grant and popped on rvalid,
// and per-cycle checks on the memory-side request fields.
module tb_mem_arbiter;
  localparam int AW = 64, DW = 64, MW = DW / 8, TO = 4;

  logic          clk = 1'b0, rst;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0000_0010_0073;
    return {a[31:0], ~a[31:0]};
  endfunction

  // memory model knobs (changed only while the model is idle)
  int ready_dly = 0, rsp_dly = 0, late_dly = 0;
  bit no_rsp = 0, model_busy = 0;

  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid) begin
        int d;
        model_busy = 1;
        repeat (ready_dly) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        if (!no_rsp && rsp_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = mem_fn(mem_addr); end
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        d = no_rsp ? late_dly : rsp_dly;
        if (d > 0) begin
          repeat (d - 1) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1;
          mem_rdata  = no_rsp ? 64'h5A5A_5A5A_5A5A_5A5A : mem_fn(mem_addr);
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = '0;
        end
        model_busy = 0;
      end
    end
  end

  typedef struct {bit lsu; logic [63:0] rdata; bit err; int cyc;} exp_t;
  exp_t sb[$];
  bit   ord[$];

  bit            prev_gnt = 0, prev_mv = 0;
  logic          p_we, s_we;
  logic [AW-1:0] p_addr, s_addr;
  logic [DW-1:0] p_wdata, s_wdata;
  logic [MW-1:0] p_wmask, s_wmask;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_gnt = 0; prev_mv = 0;
    end else begin
      if (if_rvalid || lsu_rvalid) begin
        chk("rvalid_onehot", {63'd0, if_rvalid && lsu_rvalid}, 64'd0);
        if (sb.size() == 0) chk("rvalid_spurious", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rv_owner", {63'd0, lsu_rvalid}, {63'd0, e.lsu});
          chk("rv_cycle", 64'(cyc), 64'(e.cyc));
          chk("rv_rdata", lsu_rvalid ? lsu_rdata : if_rdata, e.rdata);
          chk("rv_err", {63'd0, lsu_rvalid ? lsu_err : if_err}, {63'd0, e.err});
        end
      end
      if (prev_gnt) begin
        chk("mv_after_gnt", {63'd0, mem_valid}, 64'd1);
        chk("mem_addr", mem_addr, p_addr);
        chk("mem_we", {63'd0, mem_we}, {63'd0, p_we});
        chk("mem_wdata", mem_wdata, p_wdata);
        chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, p_wmask});
      end else if (mem_valid && prev_mv) begin
        chk("stable_addr", mem_addr, s_addr);
        chk("stable_we", {63'd0, mem_we}, {63'd0, s_we});
        chk("stable_wdata", mem_wdata, s_wdata);
        chk("stable_wmask", {56'd0, mem_wmask}, {56'd0, s_wmask});
      end
      if (if_gnt || lsu_gnt) begin
        exp_t e;
        chk("gnt_onehot", {63'd0, if_gnt && lsu_gnt}, 64'd0);
        chk("gnt_pulse", {63'd0, prev_gnt}, 64'd0);
        p_addr  = lsu_gnt ? lsu_addr : if_addr;
        p_we    = lsu_gnt ? lsu_we : 1'b0;
        p_wdata = lsu_gnt ? lsu_wdata : '0;
        p_wmask = lsu_gnt ? lsu_wmask : '0;
        e.lsu   = lsu_gnt;
        e.err   = no_rsp;
        e.rdata = (no_rsp || p_we) ? 64'd0 : mem_fn(p_addr);
        if (no_rsp)            e.cyc = cyc + ready_dly + TO + 3;
        else if (rsp_dly == 0) e.cyc = cyc + ready_dly + 2;
        else                   e.cyc = cyc + ready_dly + rsp_dly + 2;
        sb.push_back(e);
        ord.push_back(lsu_gnt);
      end
      prev_gnt = if_gnt || lsu_gnt;
      prev_mv  = mem_valid;
      s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata; s_wmask = mem_wmask;
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || model_busy) && n < 300) begin @(posedge clk); n++; end
    chk(tag, {63'd0, n < 300}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic req_if(input logic [AW-1:0] a);
    int n = 0;
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    while (!if_gnt && n < 100) begin @(negedge clk); n++; end
    chk("if_gnt_wait", {63'd0, n < 100}, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic req_lsu(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    int n = 0;
    lsu_req = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wmask = wm;
    @(negedge clk);
    while (!lsu_gnt && n < 100) begin @(negedge clk); n++; end
    chk("lsu_gnt_wait", {63'd0, n < 100}, 64'd1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

  // Both requesters held until ntx grants are seen; first = negedge index of the first grant.
  task automatic do_tie(input int ntx, output int first);
    int g = 0, n = 0;
    first = -1;
    ord.delete();
    if_req = 1'b1; if_addr = 64'h8000_0100;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_2000; lsu_wdata = 64'h1111; lsu_wmask = 8'hFF;
    while (g < ntx && n < 200) begin
      @(negedge clk); n++;
      if (if_gnt || lsu_gnt) begin g++; if (first < 0) first = n; end
    end
    chk("tie_grants", 64'(g), 64'(ntx));
    @(posedge clk); #1;
    if_req = 1'b0; lsu_req = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mv"}, {63'd0, mem_valid}, 64'd0);
    chk({tag, "_gnt"}, {62'd0, if_gnt, lsu_gnt}, 64'd0);
    chk({tag, "_rv"}, {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    chk({tag, "_err"}, {62'd0, if_err, lsu_err}, 64'd0);
    chk({tag, "_if_rdata"}, if_rdata, 64'd0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wm"}, {55'd0, mem_we, mem_wmask}, 64'd0);
  endtask

  initial begin
    int first;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("post_rst");

    // ties alternate, LSU first out of reset
    do_tie(4, first);
    chk("tie_immediate", 64'(first), 64'd1);
    chk("tie_count", 64'(ord.size()), 64'd4);
    for (int i = 0; i < 4 && i < ord.size(); i++)
      chk("tie_order", {63'd0, ord[i]}, {63'd0, (i % 2) == 0});
    wait_done("tie_drain");

    // IF alone, zero-wait memory
    req_if(64'h8000_0000);
    wait_done("if_zero_wait");
    chk("if_rdata_hold", if_rdata, 64'h0010_0073);

    // LSU write with ready after 3 cycles, response 2 later
    ready_dly = 3; rsp_dly = 2;
    req_lsu(1'b1, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    wait_done("lsu_write");

    // timeout: accepted, never answered; late response dropped
    ready_dly = 0; rsp_dly = 0; no_rsp = 1; late_dly = 7;
    req_lsu(1'b0, 64'h8000_3000, '0, '0);
    wait_done("timeout");
    no_rsp = 0; late_dly = 0;
    req_if(64'h8000_4000);
    wait_done("if_after_timeout");

    // reset while in WAIT, then a stray memory response
    no_rsp = 1; late_dly = 3;
    req_lsu(1'b0, 64'h8000_5000, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("rst_wait_mv", {63'd0, mem_valid}, 64'd0);
    chk("rst_wait_rv", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    chk("rst_wait_if_rdata", if_rdata, 64'd0);
    chk("rst_wait_addr", mem_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done("rst_drain");
    no_rsp = 0; late_dly = 0;
    do_tie(1, first);
    chk("rst_tie_immediate", 64'(first), 64'd1);
    chk("rst_tie_lsu", {63'd0, ord.size() > 0 && ord[0]}, 64'd1);
    wait_done("rst_tie_drain");

    // memory holds off mem_ready for 10 cycles; no counter advance, no timeout
    ready_dly = 10;
    req_if(64'h8000_6000);
    wait_done("ready_stall");
    ready_dly = 0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
